// File: rtl/sipo_capture_ctrl_if.sv
// Parallel-word handshake between the SIPO capture sequencer and its consumer.
// The master side presents the captured word; the slave side returns ready.
interface sipo_capture_ctrl_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] frame_data;
    logic             frame_valid;
    logic             frame_ready;
    logic             parity_err;

    modport master (
        output frame_data,
        output frame_valid,
        output parity_err,
        input  frame_ready
    );

    modport slave (
        input  frame_data,
        input  frame_valid,
        input  parity_err,
        output frame_ready
    );
endinterface

// File: rtl/sipo_capture_ctrl.sv
// Sequencer for a bidirectional SIPO shift register: clear, WIDTH shifts, hold, gap.
// Optional even-parity cycle after the data bits: define SIPO_CAPTURE_PARITY_EN.
module sipo_capture_ctrl #(
    parameter int WIDTH     = 4,
    parameter int FRAME_GAP = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start_i,
    input  logic dir_i,
    input  logic serial_in,
    sipo_capture_ctrl_if.master frame,
    output logic busy,
    output logic overrun,
    output logic sr_clear,
    output logic sr_shift_en,
    output logic sr_shift_dir
);

`ifdef SIPO_CAPTURE_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LAST = 4'(FRAME_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SHIFT,
        PAR,
        HOLD,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       gap_q, gap_d;
    logic [WIDTH-1:0] mirror_q, mirror_d;
    logic             dir_q, dir_d;
    logic             ovr_q, ovr_d;
    logic             perr_q, perr_d;
    logic             valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            gap_q    <= '0;
            mirror_q <= '0;
            dir_q    <= 1'b0;
            ovr_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            mirror_q <= mirror_d;
            dir_q    <= dir_d;
            ovr_q    <= ovr_d;
            perr_q   <= perr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        mirror_d    = mirror_q;
        dir_d       = dir_q;
        perr_d      = perr_q;
        ovr_d       = start_i && (state_q != IDLE);
        sr_clear    = 1'b0;
        sr_shift_en = 1'b0;
        valid       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    dir_d   = dir_i;
                    state_d = CLR;
                end
            end
            CLR: begin
                sr_clear = 1'b1;
                mirror_d = '0;
                cnt_d    = '0;
                perr_d   = 1'b0;
                state_d  = SHIFT;
            end
            SHIFT: begin
                sr_shift_en = 1'b1;
                mirror_d = dir_q ? {mirror_q[WIDTH-2:0], serial_in}
                                 : {serial_in, mirror_q[WIDTH-1:1]};
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = PAR_EN ? PAR : HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PAR: begin
                // mirror is complete here; even parity over data + parity bit
                perr_d  = (^mirror_q) ^ serial_in;
                state_d = HOLD;
            end
            HOLD: begin
                valid = 1'b1;
                if (frame.frame_ready) begin
                    gap_d   = '0;
                    state_d = (FRAME_GAP == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign frame.frame_valid = valid;
    assign frame.frame_data  = mirror_q;
    assign frame.parity_err  = PAR_EN & perr_q & valid;
    assign busy              = (state_q != IDLE);
    assign overrun           = ovr_q;
    assign sr_shift_dir      = dir_q;

endmodule

// File: tb/tb_sipo_capture_ctrl.sv
// Self-checking bench for sipo_capture_ctrl: vector table, random frames, corner sequences.
// Checks the optional parity cycle when SIPO_CAPTURE_PARITY_EN is defined.
module tb_sipo_capture_ctrl;

    localparam int W = 4;
`ifdef SIPO_CAPTURE_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start_i = 1'b0, dir_i = 1'b0, serial_in = 1'b0;
    logic busy, overrun, sr_clear, sr_shift_en, sr_shift_dir;
    logic start2 = 1'b0, dir2 = 1'b0, serial2 = 1'b0;
    logic busy2, overrun2, clr2, shen2, sdir2;

    int total = 0;
    int bad = 0;

    sipo_capture_ctrl_if #(.WIDTH(W)) ifc0();
    sipo_capture_ctrl_if #(.WIDTH(W)) ifc1();

    sipo_capture_ctrl #(.WIDTH(W), .FRAME_GAP(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .start_i(start_i), .dir_i(dir_i),
        .serial_in(serial_in), .frame(ifc0.master), .busy(busy),
        .overrun(overrun), .sr_clear(sr_clear), .sr_shift_en(sr_shift_en),
        .sr_shift_dir(sr_shift_dir)
    );

    sipo_capture_ctrl #(.WIDTH(W), .FRAME_GAP(3)) u_gap (
        .clk(clk), .reset_n(reset_n), .start_i(start2), .dir_i(dir2),
        .serial_in(serial2), .frame(ifc1.master), .busy(busy2),
        .overrun(overrun2), .sr_clear(clr2), .sr_shift_en(shen2),
        .sr_shift_dir(sdir2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       d;
        logic [3:0] b;
        logic       p;
        int         rdly;
        int         stray;
        logic [3:0] exp_data;
        logic       exp_perr;
    } vec_t;

    vec_t tbl[6];

    task automatic step;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // b[i] is the i-th serial bit; dir=0 fills from the MSB, dir=1 from the LSB
    function automatic logic [3:0] model_word(input logic d, input logic [3:0] b);
        logic [3:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (d) w[W-1-i] = b[i];
            else   w[i] = b[i];
        end
        return w;
    endfunction

    function automatic logic model_perr(input logic [3:0] b, input logic p);
        return ($countones({b, p}) % 2) != 0;
    endfunction

    // stray: 0 none, 1..W during that SHIFT bit, W+1 on the handshake cycle
    task automatic run_frame(input logic d, input logic [3:0] b, input logic p,
                             input int rdly, input int stray,
                             input logic [3:0] exp_data, input logic exp_perr);
        int   nsh;
        int   ncl;
        logic ps;
        nsh = 0;
        ncl = 0;
        ps  = 1'b0;
        dir_i = d;
        start_i = 1'b1;
        ifc0.frame_ready = 1'b0;
        step;
        start_i = 1'b0;
        dir_i = ~d;
        chk("clr_cycle", {busy, sr_clear, sr_shift_en, ifc0.frame_valid, sr_shift_dir, overrun},
            {1'b1, 1'b1, 1'b0, 1'b0, d, 1'b0});
        nsh += int'(sr_shift_en);
        ncl += int'(sr_clear);
        step;
        for (int i = 0; i < W; i++) begin
            chk("shift_cycle",
                {busy, sr_clear, sr_shift_en, ifc0.frame_valid, sr_shift_dir, overrun},
                {1'b1, 1'b0, 1'b1, 1'b0, d, ps});
            nsh += int'(sr_shift_en);
            ncl += int'(sr_clear);
            serial_in = b[i];
            start_i = (stray == i + 1);
            step;
            ps = start_i;
            start_i = 1'b0;
        end
        if (PAR != 0) begin
            chk("par_cycle",
                {busy, sr_clear, sr_shift_en, ifc0.frame_valid, sr_shift_dir, overrun},
                {1'b1, 1'b0, 1'b0, 1'b0, d, ps});
            nsh += int'(sr_shift_en);
            ncl += int'(sr_clear);
            serial_in = p;
            step;
            ps = 1'b0;
        end
        for (int k = 0; k <= rdly; k++) begin
            chk("hold_cycle",
                {busy, sr_clear, sr_shift_en, ifc0.frame_valid, sr_shift_dir, overrun},
                {1'b1, 1'b0, 1'b0, 1'b1, d, ps});
            chk("hold_data", ifc0.frame_data, exp_data);
            chk("hold_perr", ifc0.parity_err, exp_perr);
            nsh += int'(sr_shift_en);
            ncl += int'(sr_clear);
            serial_in = $urandom_range(0, 1);
            ifc0.frame_ready = (k == rdly);
            start_i = (k == rdly) && (stray == W + 1);
            step;
            ps = start_i;
            start_i = 1'b0;
            ifc0.frame_ready = 1'b0;
        end
        chk("after_hs", {busy, ifc0.frame_valid, overrun, sr_clear, sr_shift_en},
            {1'b0, 1'b0, ps, 1'b0, 1'b0});
        chk("n_shift", nsh, W);
        chk("n_clear", ncl, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            ifc0.frame_ready = $urandom_range(0, 1);
            step;
            chk("idle", {busy, ifc0.frame_valid, sr_clear, sr_shift_en}, 4'b0);
        end
        ifc0.frame_ready = 1'b0;
    endtask

    initial begin
        logic       d;
        logic [3:0] b;
        logic       p;
        int         hs_wait;

        ifc0.frame_ready = 1'b0;
        ifc1.frame_ready = 1'b0;

        tbl[0] = '{1'b0, 4'b1101, 1'b1, 0, 0, 4'hD, 1'b0};
        tbl[1] = '{1'b1, 4'b1101, 1'b1, 5, 0, 4'hB, 1'b0};
        tbl[2] = '{1'b0, 4'b1101, 1'b0, 0, 3, 4'hD, 1'b1};
        tbl[3] = '{1'b1, 4'b0001, 1'b1, 1, 5, 4'h8, 1'b0};
        tbl[4] = '{1'b0, 4'b0110, 1'b0, 2, 1, 4'h6, 1'b0};
        tbl[5] = '{1'b1, 4'b1111, 1'b1, 0, 0, 4'hF, 1'b1};

        // reset held with start toggling
        for (int i = 0; i < 4; i++) begin
            start_i = (i % 2) == 0;
            step;
            chk("reset_outs",
                {ifc0.frame_data, ifc0.frame_valid, ifc0.parity_err, busy,
                 overrun, sr_clear, sr_shift_en, sr_shift_dir}, 32'h0);
        end
        start_i = 1'b0;
        reset_n = 1'b1;
        step;
        chk("post_reset", {busy, ifc0.frame_valid, overrun}, 3'b000);

        for (int t = 0; t < 6; t++) begin
            run_frame(tbl[t].d, tbl[t].b, tbl[t].p, tbl[t].rdly, tbl[t].stray,
                      tbl[t].exp_data, tbl[t].exp_perr & (PAR != 0));
            idle(1);
        end

        for (int n = 0; n < 40; n++) begin
            d = 1'($urandom_range(0, 1));
            b = 4'($urandom_range(0, 15));
            p = 1'($urandom_range(0, 1));
            run_frame(d, b, p, $urandom_range(0, 3),
                      ($urandom_range(0, 1) != 0) ? $urandom_range(1, W + 1) : 0,
                      model_word(d, b), model_perr(b, p) & (PAR != 0));
            idle($urandom_range(0, 2));
        end

        // stray start mid-shift then asynchronous reset mid-frame
        dir_i = 1'b1;
        start_i = 1'b1;
        step;
        start_i = 1'b0;
        serial_in = 1'b1;
        step;
        step;
        step;
        start_i = 1'b1;
        step;
        start_i = 1'b0;
        chk("ovr_midframe", {overrun, busy, sr_shift_en}, 3'b111);
        reset_n = 1'b0;
        #1;
        chk("async_reset",
            {ifc0.frame_data, ifc0.frame_valid, ifc0.parity_err, busy,
             overrun, sr_clear, sr_shift_en, sr_shift_dir}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step;
            chk("reset_hold", {ifc0.frame_valid, busy}, 2'b00);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step;
            chk("no_valid_after", {ifc0.frame_valid, busy}, 2'b00);
        end

        // FRAME_GAP=3 instance: start during gap dropped, 4 cycles after accepted
        dir2 = 1'b0;
        serial2 = 1'b1;
        ifc1.frame_ready = 1'b1;
        start2 = 1'b1;
        step;
        start2 = 1'b0;
        hs_wait = 0;
        while (!ifc1.frame_valid && hs_wait < 20) begin
            step;
            hs_wait++;
        end
        chk("gap_valid_lat", hs_wait, W + 1 + PAR);
        chk("gap_data", ifc1.frame_data, 4'hF);
        step;
        chk("gap_h1", {busy2, ifc1.frame_valid}, 2'b10);
        start2 = 1'b1;
        step;
        start2 = 1'b0;
        chk("gap_ovr", {overrun2, busy2}, 2'b11);
        step;
        chk("gap_h3", {overrun2, busy2}, 2'b01);
        step;
        chk("gap_h4_idle", {overrun2, busy2}, 2'b00);
        start2 = 1'b1;
        step;
        start2 = 1'b0;
        chk("gap_accept", {busy2, clr2, overrun2}, 3'b110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
